mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multicycle control unit for the RV32I core. It decodes the instruction register and sequences fetch, decode, execute, memory and writeback.
- It drives the datapath mux selects, the write enables and the 4-bit ALUControl code.
- It consumes the ALU flags Zero, Negative, Carry and Overflow to resolve conditional branches.
- It is the producing/consuming end of the ALU control-and-flag interface.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instr  input  32  instruction register contents
- Zero  input  1  ALU result == 0
- Negative  input  1  ALU result bit 31
- Carry  input  1  ALU carry-out (for SUB: 1 means SrcA >= SrcB unsigned)
- Overflow  input  1  ALU signed overflow
- PCWrite  output  1  PC load enable
- AdrSrc  output  1  memory address: 0=PC, 1=Result
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  IR/OldPC load enable
- RegWrite  output  1  register file write enable
- ResultSrc  output  2  00=ALUOut, 01=ReadData, 10=ALUResult
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1, 11=zero
- ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=constant 4
- ALUControl  output  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SRL, 1000 SRA, 1001 SLL
- ImmSrc  output  3  000=I, 001=S, 010=B, 011=J, 100=U; combinational from opcode
- illegal_instr  output  1  high while in TRAP
- state  output  4  current state, for debug

Behaviour:
- Clock, reset and output timing:
  - One clock domain.
  - The state register resets asynchronously to FETCH.
  - While rst_n=0, all enables (PCWrite, MemWrite, IRWrite, RegWrite) and illegal_instr are forced to 0. All selects and ALUControl are 0.
  - Outputs are Moore, decoded from state. ALUControl and branch-taken also use instr.
- States and transitions:
  - FETCH(0): AdrSrc=0, IRWrite=1, SrcA=00, SrcB=10, ADD, ResultSrc=10, PCWrite=1. Next: DECODE.
  - DECODE(1): SrcA=01, SrcB=01, ADD. This latches the branch/JAL target into ALUOut. Next state is chosen by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR1
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - any other opcode -> TRAP
  - MEMADR(2): SrcA=10, SrcB=01, ADD. Next: MEMREAD for a load, MEMWRITE for a store.
  - MEMREAD(3): ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB(4): ResultSrc=01, RegWrite=1. Next: FETCH.
  - MEMWRITE(5): ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
  - EXECR(6): SrcA=10, SrcB=00, ALU op decoded. Next: ALUWB.
  - EXECI(8): SrcA=10, SrcB=01, ALU op decoded. Next: ALUWB.
  - ALUWB(7): ResultSrc=00, RegWrite=1. Next: FETCH.
  - BRANCH(10): SrcA=10, SrcB=00, SUB, ResultSrc=00. PCWrite=taken. Next: FETCH.
  - JAL(9): SrcA=01, SrcB=10, ADD, ResultSrc=00, PCWrite=1. Next: ALUWB, which writes PC+4 to rd.
  - JALR1(11): SrcA=10, SrcB=01, ADD. Next: JALR2.
  - JALR2(12): SrcA=01, SrcB=10, ADD, ResultSrc=00, PCWrite=1. Next: ALUWB. Target bit 0 is not cleared.
  - LUI(13): SrcA=11, SrcB=01, ADD. Next: ALUWB.
  - AUIPC(14): SrcA=01, SrcB=01, ADD. Next: ALUWB.
  - TRAP(15): all enables 0, illegal_instr=1. Held until reset.
- ALU op decode (funct3 = instr[14:12]):
  - 000: ADD; SUB when R-type and instr[30]=1.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 101: SRA if instr[30]=1, else SRL. Applies to both R-type and I-type.
- Branch taken (funct3):
  - 000 beq: Zero; 001 bne: !Zero
  - 100 blt: Negative^Overflow; 101 bge: !(Negative^Overflow)
  - 110 bltu: !Carry; 111 bgeu: Carry
  - 010/011: not taken
- Cycles per instruction: load 5, store 4, R/I-type 4, branch 3, jal 4, jalr 5, lui/auipc 4.
- Reset asserted mid-instruction: the FSM returns to FETCH immediately and no partial write occurs after reset deasserts.

Test Plan:
- Reset low during MEMWRITE -> state=0 and all enables 0 within the same cycle. After release, the first cycle shows FETCH with IRWrite=1, PCWrite=1.
- instr=0x002081B3 (add x3,x1,x2) -> states 0,1,6,7,0. ALUControl=0000 in EXECR. RegWrite=1 only in ALUWB.
- instr=0x402081B3 (sub) -> ALUControl=0001. instr=0x4020D193 (srai) -> ALUControl=1000, ALUSrcB=01.
- instr=0x00208463 (beq), Zero=1 -> PCWrite=1 in BRANCH. Same instruction with Zero=0 -> PCWrite=0. blt (0x0020C463) with Negative=1, Overflow=1 -> not taken.
- instr=0x0000A183 (lw) -> 5 cycles, ResultSrc=01 in MEMWB. instr=0x0020A223 (sw) -> MemWrite=1 only in state 5, ImmSrc=001.
- instr=0xFFFFFFFF -> TRAP, illegal_instr=1 and held for 20 cycles until rst_n pulses low.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/mem/wb
// and drives datapath selects, enables and ALUControl.
module mc_control_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        Negative,
  input  logic        Carry,
  input  logic        Overflow,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic [2:0]  ImmSrc,
  output logic        illegal_instr,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10,
    JALR1    = 4'd11,
    JALR2    = 4'd12,
    LUI      = 4'd13,
    AUIPC    = 4'd14,
    TRAP     = 4'd15
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;

  state_t cur_state;
  state_t nxt_state;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_load;
  logic       is_store;
  logic       is_rtype;
  logic       is_itype;
  logic       is_branch;
  logic       is_jal;
  logic       is_jalr;
  logic       is_lui;
  logic       is_auipc;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign is_load   = opcode == 7'b0000011;
  assign is_store  = opcode == 7'b0100011;
  assign is_rtype  = opcode == 7'b0110011;
  assign is_itype  = opcode == 7'b0010011;
  assign is_branch = opcode == 7'b1100011;
  assign is_jal    = opcode == 7'b1101111;
  assign is_jalr   = opcode == 7'b1100111;
  assign is_lui    = opcode == 7'b0110111;
  assign is_auipc  = opcode == 7'b0010111;

  logic [3:0] alu_op;
  logic       taken;
  logic [2:0] imm_sel;

  always_comb begin
    alu_op = ALU_ADD;
    unique case (funct3)
      3'b000: alu_op = (is_rtype && instr[30]) ? ALU_SUB : ALU_ADD;
      3'b001: alu_op = ALU_SLL;
      3'b010: alu_op = ALU_SLT;
      3'b011: alu_op = ALU_SLTU;
      3'b100: alu_op = ALU_XOR;
      3'b101: alu_op = instr[30] ? ALU_SRA : ALU_SRL;
      3'b110: alu_op = ALU_OR;
      3'b111: alu_op = ALU_AND;
    endcase
  end

  // Flags come from SrcA - SrcB computed in the BRANCH state.
  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = Negative ^ Overflow;
      3'b101:  taken = !(Negative ^ Overflow);
      3'b110:  taken = !Carry;
      3'b111:  taken = Carry;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    imm_sel = 3'b000;
    unique case (1'b1)
      is_store:           imm_sel = 3'b001;
      is_branch:          imm_sel = 3'b010;
      is_jal:             imm_sel = 3'b011;
      is_lui || is_auipc: imm_sel = 3'b100;
      default:            imm_sel = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= state_t'(RESET_STATE);
    else        cur_state <= nxt_state;
  end

  logic       pc_w;
  logic       adr;
  logic       mem_w;
  logic       ir_w;
  logic       reg_w;
  logic [1:0] res;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [3:0] alu;
  logic       ill;

  always_comb begin
    nxt_state = cur_state;
    pc_w  = 1'b0;
    adr   = 1'b0;
    mem_w = 1'b0;
    ir_w  = 1'b0;
    reg_w = 1'b0;
    res   = 2'b00;
    src_a = 2'b00;
    src_b = 2'b00;
    alu   = ALU_ADD;
    ill   = 1'b0;
    unique case (cur_state)
      FETCH: begin
        ir_w  = 1'b1;
        pc_w  = 1'b1;
        src_b = 2'b10;
        res   = 2'b10;
        nxt_state = DECODE;
      end
      DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        unique case (1'b1)
          is_load || is_store: nxt_state = MEMADR;
          is_rtype:            nxt_state = EXECR;
          is_itype:            nxt_state = EXECI;
          is_branch:           nxt_state = BRANCH;
          is_jal:              nxt_state = JAL;
          is_jalr:             nxt_state = JALR1;
          is_lui:              nxt_state = LUI;
          is_auipc:            nxt_state = AUIPC;
          default:             nxt_state = TRAP;
        endcase
      end
      MEMADR: begin
        src_a = 2'b10;
        src_b = 2'b01;
        nxt_state = is_store ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr = 1'b1;
        nxt_state = MEMWB;
      end
      MEMWB: begin
        res   = 2'b01;
        reg_w = 1'b1;
        nxt_state = FETCH;
      end
      MEMWRITE: begin
        adr   = 1'b1;
        mem_w = 1'b1;
        nxt_state = FETCH;
      end
      EXECR: begin
        src_a = 2'b10;
        alu   = alu_op;
        nxt_state = ALUWB;
      end
      EXECI: begin
        src_a = 2'b10;
        src_b = 2'b01;
        alu   = alu_op;
        nxt_state = ALUWB;
      end
      ALUWB: begin
        reg_w = 1'b1;
        nxt_state = FETCH;
      end
      BRANCH: begin
        src_a = 2'b10;
        alu   = ALU_SUB;
        pc_w  = taken;
        nxt_state = FETCH;
      end
      // Target already sits in ALUOut; ALU forms the link value.
      JAL, JALR2: begin
        src_a = 2'b01;
        src_b = 2'b10;
        pc_w  = 1'b1;
        nxt_state = ALUWB;
      end
      JALR1: begin
        src_a = 2'b10;
        src_b = 2'b01;
        nxt_state = JALR2;
      end
      LUI: begin
        src_a = 2'b11;
        src_b = 2'b01;
        nxt_state = ALUWB;
      end
      AUIPC: begin
        src_a = 2'b01;
        src_b = 2'b01;
        nxt_state = ALUWB;
      end
      TRAP: begin
        ill = 1'b1;
        nxt_state = TRAP;
      end
    endcase
  end

  assign PCWrite       = rst_n & pc_w;
  assign AdrSrc        = rst_n & adr;
  assign MemWrite      = rst_n & mem_w;
  assign IRWrite       = rst_n & ir_w;
  assign RegWrite      = rst_n & reg_w;
  assign ResultSrc     = rst_n ? res : 2'b00;
  assign ALUSrcA       = rst_n ? src_a : 2'b00;
  assign ALUSrcB       = rst_n ? src_b : 2'b00;
  assign ALUControl    = rst_n ? alu : 4'b0000;
  assign ImmSrc        = rst_n ? imm_sel : 3'b000;
  assign illegal_instr = rst_n & ill;
  assign state         = cur_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed and random instructions checked
// cycle by cycle against an expected per-instruction state trace.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        Zero = 1'b0;
  logic        Negative = 1'b0;
  logic        Carry = 1'b0;
  logic        Overflow = 1'b0;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUControl;
  logic [2:0]  ImmSrc;
  logic        illegal_instr;
  logic [3:0]  state;

  mc_control_fsm dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr(instr),
    .Zero(Zero),
    .Negative(Negative),
    .Carry(Carry),
    .Overflow(Overflow),
    .PCWrite(PCWrite),
    .AdrSrc(AdrSrc),
    .MemWrite(MemWrite),
    .IRWrite(IRWrite),
    .RegWrite(RegWrite),
    .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl),
    .ImmSrc(ImmSrc),
    .illegal_instr(illegal_instr),
    .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [19:0] obs;
  assign obs = {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUControl, illegal_instr};

  // Record: state pcw adr memw irw regw res srca srcb alu ill
  function automatic logic [19:0] rec(int st, int pcw, int adr, int mw,
                                      int irw, int rw, int res, int sa,
                                      int sb, int alu, int ill);
    return {st[3:0], pcw[0], adr[0], mw[0], irw[0], rw[0],
            res[1:0], sa[1:0], sb[1:0], alu[3:0], ill[0]};
  endfunction

  function automatic int alu_of(logic [31:0] ins, bit rtype);
    int tbl[8] = '{0, 9, 5, 6, 4, 7, 3, 2};
    logic [2:0] f3;
    int op;
    f3 = ins[14:12];
    op = tbl[f3];
    if (f3 == 3'd0 && rtype && ins[30]) op = 1;
    if (f3 == 3'd5 && ins[30]) op = 8;
    return op;
  endfunction

  function automatic bit br_ref(logic [2:0] f3, logic [31:0] a,
                                logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(logic [31:0] ins);
    case (ins[6:0])
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    Zero = (d == 32'h0);
    Negative = d[31];
    Carry = (a >= b);
    Overflow = (a[31] != b[31]) && (d[31] != a[31]);
  endtask

  logic [19:0] exp_q[$];

  task automatic build(input logic [31:0] ins, input bit tk);
    logic [19:0] wb;
    wb = rec(7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    exp_q.delete();
    exp_q.push_back(rec(0, 1, 0, 0, 1, 0, 2, 0, 2, 0, 0));
    exp_q.push_back(rec(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    case (ins[6:0])
      7'b0000011: begin
        exp_q.push_back(rec(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        exp_q.push_back(rec(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(rec(4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      end
      7'b0100011: begin
        exp_q.push_back(rec(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        exp_q.push_back(rec(5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      end
      7'b0110011: begin
        exp_q.push_back(rec(6, 0, 0, 0, 0, 0, 0, 2, 0,
                            alu_of(ins, 1'b1), 0));
        exp_q.push_back(wb);
      end
      7'b0010011: begin
        exp_q.push_back(rec(8, 0, 0, 0, 0, 0, 0, 2, 1,
                            alu_of(ins, 1'b0), 0));
        exp_q.push_back(wb);
      end
      7'b1100011:
        exp_q.push_back(rec(10, int'(tk), 0, 0, 0, 0, 0, 2, 0, 1, 0));
      7'b1101111: begin
        exp_q.push_back(rec(9, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        exp_q.push_back(wb);
      end
      7'b1100111: begin
        exp_q.push_back(rec(11, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        exp_q.push_back(rec(12, 1, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        exp_q.push_back(wb);
      end
      7'b0110111: begin
        exp_q.push_back(rec(13, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
        exp_q.push_back(wb);
      end
      7'b0010111: begin
        exp_q.push_back(rec(14, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        exp_q.push_back(wb);
      end
      default:
        for (int i = 0; i < 20; i++)
          exp_q.push_back(rec(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    endcase
  endtask

  // Called at posedge+1 with the FSM in FETCH; cut>0 stops early
  // without advancing past the last checked cycle.
  task automatic run(input string name, input logic [31:0] ins,
                     input logic [31:0] a, input logic [31:0] b,
                     input int cut);
    int n;
    instr = ins;
    set_ops(a, b);
    build(ins, br_ref(ins[14:12], a, b));
    #1;
    chk({name, " imm"}, 32'(ImmSrc), 32'(imm_of(ins)));
    n = (cut > 0) ? cut : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s c%0d", name, i), 32'(obs), 32'(exp_q[i]));
      if (!(cut > 0 && i == n - 1)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic pulse_reset(input string name);
    rst_n = 1'b0;
    #1;
    chk({name, " rst"}, 32'(obs), 32'h0);
    @(posedge clk);
    #1;
    chk({name, " rst hold"}, 32'(obs), 32'h0);
    rst_n = 1'b1;
  endtask

  logic [6:0] opc_tbl[9] = '{7'b0000011, 7'b0100011, 7'b0110011,
                             7'b0010011, 7'b1100011, 7'b1101111,
                             7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [31:0] b;
    #2;
    chk("reset", 32'(obs), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run("add", 32'h002081B3, 32'd1, 32'd2, 0);
    run("sub", 32'h402081B3, 32'd1, 32'd2, 0);
    run("srai", 32'h4020D193, 32'd1, 32'd2, 0);
    run("beq_t", 32'h00208463, 32'd5, 32'd5, 0);
    run("beq_n", 32'h00208463, 32'd5, 32'd6, 0);
    run("blt_nv", 32'h0020C463, 32'h7FFFFFFF, 32'hFFFFFFFF, 0);
    run("bltu", 32'h0020E463, 32'h1, 32'hFFFFFFFF, 0);
    run("lw", 32'h0000A183, 32'd0, 32'd0, 0);
    run("sw", 32'h0020A223, 32'd0, 32'd0, 0);
    run("jal", 32'h0000006F, 32'd0, 32'd0, 0);
    run("jalr", 32'h00008067, 32'd0, 32'd0, 0);
    run("lui", 32'h000010B7, 32'd0, 32'd0, 0);
    run("auipc", 32'h00001097, 32'd0, 32'd0, 0);

    run("sw_cut", 32'h0020A223, 32'd0, 32'd0, 4);
    pulse_reset("sw_cut");
    run("post_rst", 32'h002081B3, 32'd3, 32'd4, 0);

    run("trap", 32'hFFFFFFFF, 32'd0, 32'd0, 22);
    pulse_reset("trap");
    run("post_trap", 32'h402081B3, 32'd3, 32'd4, 0);

    for (int k = 0; k < 150; k++) begin
      r = $urandom;
      r[6:0] = opc_tbl[$urandom_range(0, 8)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run($sformatf("rnd%0d", k), r, a, b, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
